// File: rtl/gradient_sum_tx_packer.sv
// Packs per-batch float sums into framed AXI-Stream messages: one header {seq,len} word, then len sums.
// Latency: header TVALID rises one edge after the sum completing a group is written; one word/cycle after.
// Backpressure: input has none (drops when FIFO full, sticky overflow); output holds words until TREADY.
module gradient_sum_tx_packer #(
    parameter int FLOAT_SIZE      = 32,
    parameter int BATCHES_PER_MSG = 8,
    parameter int FIFO_ADDR_BITS  = 5,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOAT_SIZE-1:0] s_axis_sum_TDATA,
    input  logic                  s_axis_sum_TVALID,
    output logic [31:0]           m_axis_tx_TDATA,
    output logic                  m_axis_tx_TVALID,
    input  logic                  m_axis_tx_TREADY,
    output logic                  m_axis_tx_TLAST,
    output logic                  overflow
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int CNT_W = FIFO_ADDR_BITS + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] BPM_C      = CNT_W'(BATCHES_PER_MSG);
    localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t                    state;
    logic [FLOAT_SIZE-1:0]     mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [TMO_W-1:0]          tmo;
    logic [15:0]               seq;
    logic [15:0]               remaining;
    logic [15:0]               len_next;
    logic [FLOAT_SIZE-1:0]     head;
    logic                      push;
    logic                      pop;
    logic                      start;

    // Fullness is judged on the pre-pop count, so a push into a full FIFO is lost even if a pop coincides.
    assign push = s_axis_sum_TVALID && (count < DEPTH_C);

    // A FIFO word is consumed at the moment it is loaded into the output register.
    assign pop = m_axis_tx_TREADY &&
                 ((state == HEADER) || ((state == PAYLOAD) && (remaining != 16'd1)));

    assign head     = mem[rd_ptr];
    assign len_next = (count >= BPM_C) ? 16'(BPM_C) : 16'(count);
    assign start    = (state == IDLE) &&
                      ((count >= BPM_C) || ((count != '0) && (tmo == TMO_LAST_C)));

    // FIFO storage: registered write, first-word-fall-through read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_sum_TDATA;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (s_axis_sum_TVALID && (count == DEPTH_C)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Message framing FSM with registered AXI-Stream outputs and idle-flush timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            m_axis_tx_TDATA  <= '0;
            m_axis_tx_TVALID <= 1'b0;
            m_axis_tx_TLAST  <= 1'b0;
            seq              <= '0;
            remaining        <= '0;
            tmo              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining        <= len_next;
                        m_axis_tx_TDATA  <= {seq, len_next};
                        m_axis_tx_TVALID <= 1'b1;
                        m_axis_tx_TLAST  <= 1'b0;
                        tmo              <= '0;
                        state            <= HEADER;
                    end else if ((count == '0) || (count >= BPM_C)) begin
                        tmo <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                HEADER: begin
                    tmo <= '0;
                    if (m_axis_tx_TREADY) begin
                        m_axis_tx_TDATA <= 32'(head);
                        m_axis_tx_TLAST <= (remaining == 16'd1);
                        state           <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    tmo <= '0;
                    if (m_axis_tx_TREADY) begin
                        if (remaining == 16'd1) begin
                            m_axis_tx_TVALID <= 1'b0;
                            m_axis_tx_TLAST  <= 1'b0;
                            seq              <= seq + 16'd1;
                            state            <= IDLE;
                        end else begin
                            m_axis_tx_TDATA <= 32'(head);
                            m_axis_tx_TLAST <= (remaining == 16'd2);
                            remaining       <= remaining - 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gradient_sum_tx_packer.sv
// Randomized bench for gradient_sum_tx_packer against a queue-based message reference model.
// Inputs change 1ns after the rising edge; the stream monitor samples on the falling edge.
// Output stall stability, framing, ordering, seq and overflow are all scored through one check task.
module tb_gradient_sum_tx_packer;
    localparam int BPM   = 8;
    localparam int DEPTH = 32;
    localparam int TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_dat;
    logic        s_vld;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        overflow;

    always #5 clk = ~clk;

    gradient_sum_tx_packer #(
        .FLOAT_SIZE     (32),
        .BATCHES_PER_MSG(BPM),
        .FIFO_ADDR_BITS (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_sum_TDATA (s_dat),
        .s_axis_sum_TVALID(s_vld),
        .m_axis_tx_TDATA  (tdata),
        .m_axis_tx_TVALID (tvalid),
        .m_axis_tx_TREADY (tready),
        .m_axis_tx_TLAST  (tlast),
        .overflow         (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: accepted sums not yet seen on the output, in order
    logic [31:0] exp_q[$];
    logic [15:0] exp_seq;
    int          msg_lens[$];
    int          msg_done;
    bit          in_msg;
    int          remaining;
    int          pay_cnt;
    bit          mon_en = 1'b0;
    bit          rnd_rdy = 1'b0;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] last_hdr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Stream monitor: everything seen here handshakes on the following rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_vld", tvalid, 1);
                check("stall_dat", tdata, prev_data);
                check("stall_last", tlast, prev_last);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (tvalid && tready) begin
                if (!in_msg) begin
                    last_hdr = tdata;
                    check("hdr_seq", tdata[31:16], exp_seq);
                    check("hdr_len_ok", (tdata[15:0] >= 1) && (tdata[15:0] <= BPM) &&
                                        (int'(tdata[15:0]) <= exp_q.size()), 1);
                    check("hdr_tlast", tlast, 0);
                    msg_lens.push_back(int'(tdata[15:0]));
                    remaining = int'(tdata[15:0]);
                    pay_cnt   = 0;
                    in_msg    = 1'b1;
                end else if (exp_q.size() == 0) begin
                    check("pay_unexpected", 1, 0);
                end else begin
                    check("pay_data", tdata, exp_q.pop_front());
                    remaining--;
                    pay_cnt++;
                    check("pay_tlast", tlast, remaining == 0);
                    if (remaining == 0) begin
                        in_msg = 1'b0;
                        exp_seq++;
                        msg_done++;
                    end
                end
            end
        end
    end

    task automatic cycle(input logic vld, input logic [31:0] d);
        s_vld = vld;
        s_dat = d;
        if (rnd_rdy) tready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        s_vld = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        exp_q.push_back(d);
        cycle(1'b1, d);
    endtask

    task automatic clear_model();
        exp_q.delete();
        msg_lens.delete();
        exp_seq    = '0;
        msg_done   = 0;
        in_msg     = 1'b0;
        pay_cnt    = 0;
        remaining  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        s_vld   = 1'b0;
        s_dat   = '0;
        rnd_rdy = 1'b0;
        tready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_msgs(input string tag, input int target, input int budget);
        int k = 0;
        while (msg_done < target && k < budget) begin
            cycle(1'b0, '0);
            k++;
        end
        check(tag, msg_done, target);
    endtask

    initial begin
        logic [31:0] ones [8];
        int n;
        int acc;
        ones = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

        // reset state
        do_reset();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_overflow", overflow, 0);

        // 1: full group back-to-back, header one edge after 8th write
        for (int i = 0; i < 8; i++) begin
            push(ones[i]);
            check("t1_no_early_hdr", tvalid, 0);
        end
        cycle(1'b0, '0);
        check("t1_hdr_vld", tvalid, 1);
        check("t1_hdr_word", tdata, 32'h0000_0008);
        wait_msgs("t1_msgs", 1, 40);
        check("t1_len", msg_lens[0], 8);

        // 2: partial group flushed by idle timeout
        do_reset();
        n = 0;
        push($urandom);
        while (n < 1100 && !tvalid) begin
            n++;
            if (n < 3) push($urandom);
            else cycle(1'b0, '0);
        end
        check("t2_flush_edges", n, TMO);
        check("t2_hdr_word", tdata, 32'h0000_0003);
        wait_msgs("t2_msgs", 1, 40);
        push($urandom);
        wait_msgs("t2_msgs2", 2, 1200);
        check("t2_hdr2_word", last_hdr, 32'h0001_0001);

        // 3: nine sums -> full message then a one-word flush
        do_reset();
        for (int i = 0; i < 9; i++) push($urandom);
        wait_msgs("t3_msgs", 2, 1200);
        check("t3_len0", msg_lens[0], 8);
        check("t3_len1", msg_lens[1], 1);
        check("t3_hdr2_word", last_hdr, 32'h0001_0001);

        // 4: random TREADY, 64 sums with random gaps
        do_reset();
        rnd_rdy = 1'b1;
        n = 0;
        while (n < 64) begin
            if ($urandom_range(0, 1) == 1 && exp_q.size() < 24) begin
                push($urandom);
                n++;
            end else begin
                cycle(1'b0, '0);
            end
        end
        wait_msgs("t4_msgs", 8, 600);
        for (int i = 0; i < msg_lens.size(); i++) check("t4_len", msg_lens[i], 8);
        check("t4_overflow", overflow, 0);
        rnd_rdy = 1'b0;
        tready  = 1'b1;

        // 5: stalled output, 40 pushes overflow a 32-deep FIFO
        do_reset();
        tready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (acc < DEPTH) begin
                exp_q.push_back(32'(i));
                acc++;
            end
            cycle(1'b1, 32'(i));
            check("t5_overflow", overflow, i >= 33);
        end
        tready = 1'b1;
        wait_msgs("t5_msgs", 4, 300);
        repeat (200) cycle(1'b0, '0);
        check("t5_msgs_total", msg_done, 4);
        check("t5_left", exp_q.size(), 0);
        for (int i = 0; i < msg_lens.size(); i++) check("t5_len", msg_lens[i], 8);
        check("t5_overflow_sticky", overflow, 1);

        // 6: reset after 4th payload word of a message
        do_reset();
        for (int i = 0; i < 8; i++) push($urandom);
        n = 0;
        while (!(in_msg && pay_cnt == 4) && n < 100) begin
            cycle(1'b0, '0);
            n++;
        end
        check("t6_reached_word4", pay_cnt, 4);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("t6_async_tvalid", tvalid, 0);
        check("t6_async_tlast", tlast, 0);
        @(posedge clk);
        #1;
        clear_model();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) push($urandom);
        wait_msgs("t6_msgs", 1, 60);
        check("t6_hdr_word", last_hdr, 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
